// File: rtl/note_lane_gen.sv
// Multi-lane note position generator: each lane sweeps a shared START..END window
// by STEP per advance strobe, in wrap, bounce or one-shot mode.
module note_lane_gen #(
    parameter int unsigned LANES     = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEF_START = 140,
    parameter int unsigned DEF_END   = 156,
    parameter int unsigned DEF_STEP  = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   map,
    input  logic [LANES-1:0]       lane_en,
    input  logic [1:0]             mode,
    input  logic                   cfg_load,
    input  logic [WIDTH-1:0]       cfg_start,
    input  logic [WIDTH-1:0]       cfg_end,
    input  logic [WIDTH-1:0]       cfg_step,
    output logic [LANES-1:0]       data_en,
    output logic [LANES*WIDTH-1:0] data,
    output logic [LANES-1:0]       wrap,
    output logic [LANES-1:0]       done,
    output logic                   cfg_err
);

    localparam logic [1:0] MODE_BOUNCE  = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } lane_state_t;

    lane_state_t      state_q [LANES];
    lane_state_t      state_d [LANES];
    logic [WIDTH-1:0] pos_q   [LANES];
    logic [WIDTH-1:0] pos_d   [LANES];
    logic [WIDTH-1:0] up_next [LANES];
    logic [WIDTH-1:0] dn_next [LANES];
    logic [WIDTH:0]   up_sum  [LANES];
    logic [LANES-1:0] dir_q, dir_d;
    logic [LANES-1:0] data_en_q, data_en_d;
    logic [LANES-1:0] wrap_q, wrap_d;
    logic [LANES-1:0] done_q, done_d;
    logic             cfg_err_q, cfg_err_d;
    logic [WIDTH-1:0] start_q, end_q, step_q;
    logic [WIDTH-1:0] start_d, end_d, step_d;
    logic [WIDTH:0]   start_plus_step;
    logic [WIDTH-1:0] bounce_top, bounce_bot;

    // Clamped step targets, computed one bit wider so they cannot wrap around
    always_comb begin
        start_plus_step = {1'b0, start_q} + {1'b0, step_q};
        bounce_top = ({1'b0, end_q} >= start_plus_step) ? (end_q - step_q) : start_q;
        bounce_bot = (start_plus_step > {1'b0, end_q}) ? end_q : start_plus_step[WIDTH-1:0];
        for (int i = 0; i < LANES; i++) begin
            up_sum[i]  = {1'b0, pos_q[i]} + {1'b0, step_q};
            up_next[i] = (up_sum[i] > {1'b0, end_q}) ? end_q : up_sum[i][WIDTH-1:0];
            dn_next[i] = ({1'b0, pos_q[i]} >= start_plus_step) ? (pos_q[i] - step_q) : start_q;
        end
    end

    // Next-state: cfg_load wins over map; each lane advances independently
    always_comb begin
        start_d   = start_q;
        end_d     = end_q;
        step_d    = step_q;
        dir_d     = dir_q;
        data_en_d = data_en_q;
        done_d    = done_q;
        wrap_d    = '0;
        cfg_err_d = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            state_d[i] = state_q[i];
            pos_d[i]   = pos_q[i];
        end

        if (cfg_load) begin
            if (cfg_start <= cfg_end) begin
                start_d   = cfg_start;
                end_d     = cfg_end;
                step_d    = cfg_step;
                dir_d     = '0;
                data_en_d = '0;
                done_d    = '0;
                for (int i = 0; i < LANES; i++) begin
                    state_d[i] = IDLE;
                    pos_d[i]   = cfg_start;
                end
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (map) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_en[i]) begin
                    case (state_q[i])
                        IDLE: begin
                            state_d[i]   = RUN;
                            data_en_d[i] = 1'b1;
                        end
                        RUN: begin
                            if (mode == MODE_BOUNCE && dir_q[i]) begin
                                if (pos_q[i] <= start_q) begin
                                    dir_d[i]  = 1'b0;
                                    pos_d[i]  = bounce_bot;
                                    wrap_d[i] = 1'b1;
                                end else begin
                                    pos_d[i] = dn_next[i];
                                end
                            end else begin
                                // Non-bounce modes always run upward
                                dir_d[i] = 1'b0;
                                if (pos_q[i] >= end_q) begin
                                    wrap_d[i] = 1'b1;
                                    if (mode == MODE_BOUNCE) begin
                                        dir_d[i] = 1'b1;
                                        pos_d[i] = bounce_top;
                                    end else if (mode == MODE_ONESHOT) begin
                                        state_d[i] = DONE;
                                        done_d[i]  = 1'b1;
                                        pos_d[i]   = end_q;
                                    end else begin
                                        pos_d[i] = start_q;
                                    end
                                end else begin
                                    pos_d[i] = up_next[i];
                                end
                            end
                        end
                        DONE:    state_d[i] = DONE;
                        default: state_d[i] = IDLE;
                    endcase
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            start_q   <= WIDTH'(DEF_START);
            end_q     <= WIDTH'(DEF_END);
            step_q    <= WIDTH'(DEF_STEP);
            dir_q     <= '0;
            data_en_q <= '0;
            wrap_q    <= '0;
            done_q    <= '0;
            cfg_err_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                state_q[i] <= IDLE;
                pos_q[i]   <= WIDTH'(DEF_START);
            end
        end else begin
            start_q   <= start_d;
            end_q     <= end_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
            data_en_q <= data_en_d;
            wrap_q    <= wrap_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
            for (int i = 0; i < LANES; i++) begin
                state_q[i] <= state_d[i];
                pos_q[i]   <= pos_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            data[i*WIDTH +: WIDTH] = pos_q[i];
        end
    end

    assign data_en = data_en_q;
    assign wrap    = wrap_q;
    assign done    = done_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_note_lane_gen.sv
// Directed vector bench for note_lane_gen: table of per-cycle stimulus and
// hand-computed lane outputs, plus an async reset sequence.
module tb_note_lane_gen;

    logic        clk = 1'b0;
    logic        resetn;
    logic        map;
    logic [3:0]  lane_en;
    logic [1:0]  mode;
    logic        cfg_load;
    logic [7:0]  cfg_start, cfg_end, cfg_step;
    logic [3:0]  data_en;
    logic [31:0] data;
    logic [3:0]  wrap;
    logic [3:0]  done;
    logic        cfg_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       ld;
        logic [7:0] cs, ce, cst;
        logic [1:0] md;
        logic       mp;
        logic [3:0] en;
        logic [3:0] x_en;
        logic [7:0] x_even, x_odd;
        logic [3:0] x_wrap, x_done;
        logic       x_err;
    } vec_t;

    vec_t vecs[$];

    note_lane_gen dut (
        .clk(clk), .resetn(resetn), .map(map), .lane_en(lane_en), .mode(mode),
        .cfg_load(cfg_load), .cfg_start(cfg_start), .cfg_end(cfg_end), .cfg_step(cfg_step),
        .data_en(data_en), .data(data), .wrap(wrap), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic add(input logic ld, input logic [7:0] cs, input logic [7:0] ce,
                       input logic [7:0] cst, input logic [1:0] md, input logic mp,
                       input logic [3:0] en, input logic [3:0] x_en, input logic [7:0] x_even,
                       input logic [7:0] x_odd, input logic [3:0] x_wrap,
                       input logic [3:0] x_done, input logic x_err);
        vec_t v;
        v.ld = ld; v.cs = cs; v.ce = ce; v.cst = cst; v.md = md; v.mp = mp; v.en = en;
        v.x_en = x_en; v.x_even = x_even; v.x_odd = x_odd;
        v.x_wrap = x_wrap; v.x_done = x_done; v.x_err = x_err;
        vecs.push_back(v);
    endtask

    // Advance with no load: mode, map, lane_en, expected en/even/odd/wrap/done
    task automatic adv(input logic [1:0] md, input logic mp, input logic [3:0] en,
                       input logic [3:0] x_en, input logic [7:0] x_even, input logic [7:0] x_odd,
                       input logic [3:0] x_wrap, input logic [3:0] x_done);
        add(1'b0, 8'd0, 8'd0, 8'd0, md, mp, en, x_en, x_even, x_odd, x_wrap, x_done, 1'b0);
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] x_en, input logic [7:0] x_even,
                                 input logic [7:0] x_odd, input logic [3:0] x_wrap,
                                 input logic [3:0] x_done, input logic x_err);
        logic [31:0] x_data;
        x_data = {x_odd, x_even, x_odd, x_even};
        checks += 5;
        if (data_en !== x_en) begin
            errors++; $display("FAIL %s data_en got %b want %b", tag, data_en, x_en);
        end
        if (data !== x_data) begin
            errors++; $display("FAIL %s data got %h want %h", tag, data, x_data);
        end
        if (wrap !== x_wrap) begin
            errors++; $display("FAIL %s wrap got %b want %b", tag, wrap, x_wrap);
        end
        if (done !== x_done) begin
            errors++; $display("FAIL %s done got %b want %b", tag, done, x_done);
        end
        if (cfg_err !== x_err) begin
            errors++; $display("FAIL %s cfg_err got %b want %b", tag, cfg_err, x_err);
        end
    endtask

    initial begin
        // Defaults, wrap mode (mode 11 aliases wrap)
        adv(2'd0, 1, 4'hF, 4'hF, 140, 140, 4'h0, 4'h0);
        adv(2'd0, 1, 4'hF, 4'hF, 144, 144, 4'h0, 4'h0);
        adv(2'd0, 1, 4'hF, 4'hF, 148, 148, 4'h0, 4'h0);
        adv(2'd0, 1, 4'hF, 4'hF, 152, 152, 4'h0, 4'h0);
        adv(2'd0, 1, 4'hF, 4'hF, 156, 156, 4'h0, 4'h0);
        adv(2'd0, 1, 4'hF, 4'hF, 140, 140, 4'hF, 4'h0);
        adv(2'd3, 1, 4'hF, 4'hF, 144, 144, 4'h0, 4'h0);
        // Bounce 10..20 step 3; load with map high ignores the map
        add(1, 10, 20, 3, 2'd1, 1, 4'hF, 4'h0, 10, 10, 4'h0, 4'h0, 0);
        adv(2'd1, 1, 4'hF, 4'hF, 10, 10, 4'h0, 4'h0);
        adv(2'd1, 1, 4'hF, 4'hF, 13, 13, 4'h0, 4'h0);
        adv(2'd1, 1, 4'hF, 4'hF, 16, 16, 4'h0, 4'h0);
        adv(2'd1, 1, 4'hF, 4'hF, 19, 19, 4'h0, 4'h0);
        adv(2'd1, 1, 4'hF, 4'hF, 20, 20, 4'h0, 4'h0);
        adv(2'd1, 1, 4'hF, 4'hF, 17, 17, 4'hF, 4'h0);
        adv(2'd1, 1, 4'hF, 4'hF, 14, 14, 4'h0, 4'h0);
        adv(2'd1, 1, 4'hF, 4'hF, 11, 11, 4'h0, 4'h0);
        adv(2'd1, 1, 4'hF, 4'hF, 10, 10, 4'h0, 4'h0);
        adv(2'd1, 1, 4'hF, 4'hF, 13, 13, 4'hF, 4'h0);
        adv(2'd1, 1, 4'hF, 4'hF, 16, 16, 4'h0, 4'h0);
        // Rejected load: error pulse, nothing else moves, config kept
        add(1, 50, 40, 0, 2'd1, 1, 4'hF, 4'hF, 16, 16, 4'h0, 4'h0, 1);
        adv(2'd1, 0, 4'hF, 4'hF, 16, 16, 4'h0, 4'h0);
        adv(2'd1, 1, 4'hF, 4'hF, 19, 19, 4'h0, 4'h0);
        // One-shot 140..156
        add(1, 140, 156, 4, 2'd2, 0, 4'hF, 4'h0, 140, 140, 4'h0, 4'h0, 0);
        adv(2'd2, 1, 4'hF, 4'hF, 140, 140, 4'h0, 4'h0);
        adv(2'd2, 1, 4'hF, 4'hF, 144, 144, 4'h0, 4'h0);
        adv(2'd2, 1, 4'hF, 4'hF, 148, 148, 4'h0, 4'h0);
        adv(2'd2, 1, 4'hF, 4'hF, 152, 152, 4'h0, 4'h0);
        adv(2'd2, 1, 4'hF, 4'hF, 156, 156, 4'h0, 4'h0);
        adv(2'd2, 1, 4'hF, 4'hF, 156, 156, 4'hF, 4'hF);
        adv(2'd2, 1, 4'hF, 4'hF, 156, 156, 4'h0, 4'hF);
        adv(2'd0, 1, 4'hF, 4'hF, 156, 156, 4'h0, 4'hF);
        add(1, 140, 156, 4, 2'd0, 0, 4'hF, 4'h0, 140, 140, 4'h0, 4'h0, 0);
        // Partial lane enable
        adv(2'd0, 1, 4'h5, 4'h5, 140, 140, 4'h0, 4'h0);
        adv(2'd0, 1, 4'h5, 4'h5, 144, 140, 4'h0, 4'h0);
        adv(2'd0, 1, 4'h5, 4'h5, 148, 140, 4'h0, 4'h0);
        adv(2'd0, 1, 4'h0, 4'h5, 148, 140, 4'h0, 4'h0);
        // START=END with STEP=0: every advance is a boundary
        add(1, 30, 30, 0, 2'd0, 0, 4'hF, 4'h0, 30, 30, 4'h0, 4'h0, 0);
        adv(2'd0, 1, 4'hF, 4'hF, 30, 30, 4'h0, 4'h0);
        adv(2'd0, 1, 4'hF, 4'hF, 30, 30, 4'hF, 4'h0);
        adv(2'd1, 1, 4'hF, 4'hF, 30, 30, 4'hF, 4'h0);
        adv(2'd1, 1, 4'hF, 4'hF, 30, 30, 4'hF, 4'h0);
        adv(2'd2, 1, 4'hF, 4'hF, 30, 30, 4'hF, 4'hF);
        // Upward sum past 255 must clamp to END
        add(1, 200, 255, 100, 2'd0, 0, 4'hF, 4'h0, 200, 200, 4'h0, 4'h0, 0);
        adv(2'd0, 1, 4'hF, 4'hF, 200, 200, 4'h0, 4'h0);
        adv(2'd0, 1, 4'hF, 4'hF, 255, 255, 4'h0, 4'h0);
        adv(2'd0, 1, 4'hF, 4'hF, 200, 200, 4'hF, 4'h0);
        adv(2'd0, 1, 4'hF, 4'hF, 255, 255, 4'h0, 4'h0);
        // Bounce with downward clamp at START, then down-lane forced up by wrap mode
        add(1, 5, 250, 100, 2'd1, 0, 4'hF, 4'h0, 5, 5, 4'h0, 4'h0, 0);
        adv(2'd1, 1, 4'hF, 4'hF, 5, 5, 4'h0, 4'h0);
        adv(2'd1, 1, 4'hF, 4'hF, 105, 105, 4'h0, 4'h0);
        adv(2'd1, 1, 4'hF, 4'hF, 205, 205, 4'h0, 4'h0);
        adv(2'd1, 1, 4'hF, 4'hF, 250, 250, 4'h0, 4'h0);
        adv(2'd1, 1, 4'hF, 4'hF, 150, 150, 4'hF, 4'h0);
        adv(2'd1, 1, 4'hF, 4'hF, 50, 50, 4'h0, 4'h0);
        adv(2'd1, 1, 4'hF, 4'hF, 5, 5, 4'h0, 4'h0);
        adv(2'd1, 1, 4'hF, 4'hF, 105, 105, 4'hF, 4'h0);
        adv(2'd1, 1, 4'hF, 4'hF, 205, 205, 4'h0, 4'h0);
        adv(2'd1, 1, 4'hF, 4'hF, 250, 250, 4'h0, 4'h0);
        adv(2'd1, 1, 4'hF, 4'hF, 150, 150, 4'hF, 4'h0);
        adv(2'd0, 1, 4'hF, 4'hF, 250, 250, 4'h0, 4'h0);
        adv(2'd0, 1, 4'hF, 4'hF, 5, 5, 4'hF, 4'h0);

        resetn = 1'b0; map = 1'b0; lane_en = '0; mode = '0;
        cfg_load = 1'b0; cfg_start = '0; cfg_end = '0; cfg_step = '0;
        #12;
        check_outputs("reset", 4'h0, 140, 140, 4'h0, 4'h0, 1'b0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cfg_load  = vecs[i].ld;
            cfg_start = vecs[i].cs;
            cfg_end   = vecs[i].ce;
            cfg_step  = vecs[i].cst;
            mode      = vecs[i].md;
            map       = vecs[i].mp;
            lane_en   = vecs[i].en;
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].x_en, vecs[i].x_even,
                          vecs[i].x_odd, vecs[i].x_wrap, vecs[i].x_done, vecs[i].x_err);
        end

        // Mid-run async reset discards lanes and config; first map only arms
        cfg_load = 1'b0; mode = 2'd0; map = 1'b1; lane_en = 4'hF;
        @(posedge clk); #1;
        check_outputs("pre_rst", 4'hF, 105, 105, 4'h0, 4'h0, 1'b0);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check_outputs("async_rst", 4'h0, 140, 140, 4'h0, 4'h0, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        check_outputs("rst_arm", 4'hF, 140, 140, 4'h0, 4'h0, 1'b0);
        @(posedge clk); #1;
        check_outputs("rst_adv", 4'hF, 144, 144, 4'h0, 4'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_lane_gen.md
NOTE_LANE_GEN -- requirements
Module: note_lane_gen

Interface
REQ-001 Parameter LANES, default 4: number of independent note lanes.
REQ-002 Parameter WIDTH, default 8: bit width of each lane position value.
REQ-003 Parameter DEF_START, default 140: reset start position.
REQ-004 Parameter DEF_END, default 156: reset end position.
REQ-005 Parameter DEF_STEP, default 4: reset step size.
REQ-006 clk  input  1  clock; all state SHALL change on its rising edge.
REQ-007 resetn  input  1  reset; asynchronous, active-low.
REQ-008 map  input  1  advance strobe; one advance per cycle high.
REQ-009 lane_en  input  LANES  per-lane enable; bit i gates lane i.
REQ-010 mode  input  2  00 wrap, 01 bounce, 10 one-shot, 11 treated as wrap; sampled every cycle.
REQ-011 cfg_load  input  1  load cfg_start/cfg_end/cfg_step and restart all lanes.
REQ-012 cfg_start, cfg_end, cfg_step  input  WIDTH each  new configuration values.
REQ-013 data_en  output  LANES  bit i high once lane i is running.
REQ-014 data  output  LANES*WIDTH  lane i position at bits [i*WIDTH +: WIDTH].
REQ-015 wrap  output  LANES  one-cycle pulse on lane i boundary event.
REQ-016 done  output  LANES  lane i finished in one-shot mode.
REQ-017 cfg_err  output  1  one-cycle pulse when cfg_load is rejected.

Function
REQ-018 The block SHALL keep shadow registers START, END, STEP; they SHALL be the only values used for lane arithmetic.
REQ-019 On cfg_load with cfg_start <= cfg_end, the block SHALL capture the config and set every lane to IDLE: data=cfg_start, dir=up, data_en=0, done=0.
REQ-020 On cfg_load with cfg_start > cfg_end, the block SHALL leave shadows and lanes unchanged and pulse cfg_err for one cycle.
REQ-021 cfg_load SHALL take priority over map in the same cycle; that map SHALL be ignored for all lanes.
REQ-022 Each lane SHALL have states IDLE, RUN, DONE plus a direction bit (up/down).
REQ-023 IDLE -> RUN on a cycle with map=1 and lane_en[i]=1; data_en[i] SHALL rise the next cycle and data SHALL NOT advance on that cycle.
REQ-024 A lane SHALL only update data when state=RUN, map=1, lane_en[i]=1; otherwise data, dir and state SHALL hold.
REQ-025 Up, non-boundary (data < END): data <= min(data+STEP, END), computed in WIDTH+1 bits with no overflow.
REQ-026 Down, non-boundary (data > START): data <= max(data-STEP, START), computed without underflow.
REQ-027 Up boundary (data >= END) in wrap mode: data <= START and wrap[i] pulses.
REQ-028 Up boundary in bounce mode: dir <= down, data <= max(END-STEP, START), wrap[i] pulses.
REQ-029 Down boundary (data <= START) in bounce mode: dir <= up, data <= min(START+STEP, END), wrap[i] pulses.
REQ-030 In wrap or one-shot mode, a lane with dir=down SHALL be forced to dir=up on its next advance and advance per REQ-025/027.
REQ-031 Up boundary in one-shot mode: state -> DONE, data holds at END, done[i]=1, wrap[i] pulses; DONE SHALL exit only via cfg_load or reset.
REQ-032 STEP=0 SHALL be legal; data holds except at boundary events, which still apply.
REQ-033 START=END SHALL be legal; every advance is a boundary event with data=START.
REQ-034 Lanes SHALL be fully independent apart from the shared map, mode and shadow config.

Reset
REQ-035 On resetn low, asynchronously: START=DEF_START, END=DEF_END, STEP=DEF_STEP; all lanes IDLE, dir up, data=DEF_START.
REQ-036 On resetn low: data_en=0, wrap=0, done=0, cfg_err=0.
REQ-037 Reset asserted mid-operation SHALL discard all lane state; the first map after release SHALL only arm lanes.

Verification
REQ-038 Defaults, lane_en=all ones, mode=00, map held high -> data_en=1 after 1 cycle; data 140,144,148,152,156,140; wrap pulse on the 156->140 edge.
REQ-039 cfg_load start=10 end=20 step=3, mode=01, map high -> 10,13,16,19,20,17,14,11,10,13; wrap on the 20->17 and 10->13 edges.
REQ-040 Mode=10, defaults, map high -> data reaches 156, done=1, data stays 156 on further map; cfg_load restores IDLE with data=START.
REQ-041 cfg_load start=50 end=40 -> cfg_err pulses one cycle; lanes and config unchanged.
REQ-042 lane_en=4'b0101 with map high -> lanes 0 and 2 advance; lanes 1 and 3 stay IDLE at 140 with data_en=0.
REQ-043 cfg_load and map in the same cycle, then resetn low mid-run -> map ignored on the load cycle; reset returns all data to 140 with data_en=0.
